// File: rtl/hyperram_arbiter.sv
// Two-port round-robin arbiter and single-dword sequencer in front of hyper_xface.
// Optional per-phase watchdog is built when HRAM_ARB_TIMEOUT_EN is defined.
module hyperram_arbiter #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = 11
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        p0_req,
  input  logic        p0_we,
  input  logic [31:0] p0_addr,
  input  logic [31:0] p0_wdata,
  input  logic [3:0]  p0_be,
  output logic        p0_ack,
  output logic        p0_rvalid,
  output logic [31:0] p0_rdata,
  input  logic        p1_req,
  input  logic        p1_we,
  input  logic [31:0] p1_addr,
  input  logic [31:0] p1_wdata,
  input  logic [3:0]  p1_be,
  output logic        p1_ack,
  output logic        p1_rvalid,
  output logic [31:0] p1_rdata,
  output logic        hr_rd_req,
  output logic        hr_wr_req,
  output logic [31:0] hr_addr,
  output logic [31:0] hr_wr_d,
  output logic [3:0]  hr_wr_byte_en,
  output logic [5:0]  hr_rd_num_dwords,
  input  logic        hr_busy,
  input  logic        hr_rd_rdy,
  input  logic [31:0] hr_rd_d,
  output logic        timeout_err
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_IDLE} state_t;

  state_t state_r;
  logic   owner_r;
  logic   last_grant_r;
  logic   we_r;
  logic   grant_s;
  logic   winner_s;
  logic   rd_return_s;
  logic   timeout_hit_s;

  if ((64'd1 << CNT_W) <= 64'(TIMEOUT_CYCLES)) begin : g_cnt_w_check
    $error("CNT_W is too narrow for TIMEOUT_CYCLES");
  end

  assign hr_rd_num_dwords = 6'h01;

`ifdef HRAM_ARB_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] cnt_r;
  logic             prev_grant_r;
  logic             timeout_err_r;
  assign timeout_err = timeout_err_r;
`else
  assign timeout_err = 1'b0;
`endif

  // Winner selection, read-return qualification and watchdog expiry.
  always_comb begin
    grant_s       = 1'b0;
    winner_s      = 1'b0;
    timeout_hit_s = 1'b0;
    if (p0_req && p1_req) begin
      grant_s  = 1'b1;
      winner_s = ~last_grant_r;
    end else if (p0_req) begin
      grant_s  = 1'b1;
      winner_s = 1'b0;
    end else if (p1_req) begin
      grant_s  = 1'b1;
      winner_s = 1'b1;
    end else begin
      grant_s  = 1'b0;
      winner_s = 1'b0;
    end
`ifdef HRAM_ARB_TIMEOUT_EN
    // The phase's own exit condition takes priority over the watchdog.
    if (((state_r == WAIT_BUSY) && !hr_busy) || ((state_r == WAIT_IDLE) && hr_busy)) begin
      timeout_hit_s = (cnt_r == TO_LAST);
    end else begin
      timeout_hit_s = 1'b0;
    end
`endif
    rd_return_s = hr_rd_rdy && !we_r && !timeout_hit_s &&
                  ((state_r == WAIT_BUSY) || (state_r == WAIT_IDLE));
  end

  // Sequencer FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= IDLE;
      owner_r       <= 1'b0;
      last_grant_r  <= 1'b1;
      we_r          <= 1'b0;
      p0_ack        <= 1'b0;
      p1_ack        <= 1'b0;
      p0_rvalid     <= 1'b0;
      p1_rvalid     <= 1'b0;
      p0_rdata      <= 32'h0000_0000;
      p1_rdata      <= 32'h0000_0000;
      hr_rd_req     <= 1'b0;
      hr_wr_req     <= 1'b0;
      hr_addr       <= 32'h0000_0000;
      hr_wr_d       <= 32'h0000_0000;
      hr_wr_byte_en <= 4'h0;
`ifdef HRAM_ARB_TIMEOUT_EN
      cnt_r         <= '0;
      prev_grant_r  <= 1'b1;
      timeout_err_r <= 1'b0;
`endif
    end else begin
      p0_ack    <= 1'b0;
      p1_ack    <= 1'b0;
      p0_rvalid <= 1'b0;
      p1_rvalid <= 1'b0;
      hr_rd_req <= 1'b0;
      hr_wr_req <= 1'b0;
`ifdef HRAM_ARB_TIMEOUT_EN
      timeout_err_r <= 1'b0;
`endif
      if (rd_return_s) begin
        if (owner_r) begin
          p1_rdata  <= hr_rd_d;
          p1_rvalid <= 1'b1;
        end else begin
          p0_rdata  <= hr_rd_d;
          p0_rvalid <= 1'b1;
        end
      end
      case (state_r)
        IDLE: begin
          if (grant_s && !hr_busy) begin
            owner_r       <= winner_s;
            last_grant_r  <= winner_s;
            we_r          <= winner_s ? p1_we    : p0_we;
            hr_addr       <= winner_s ? p1_addr  : p0_addr;
            hr_wr_d       <= winner_s ? p1_wdata : p0_wdata;
            hr_wr_byte_en <= winner_s ? p1_be    : p0_be;
            p0_ack        <= ~winner_s;
            p1_ack        <= winner_s;
            state_r       <= ISSUE;
`ifdef HRAM_ARB_TIMEOUT_EN
            prev_grant_r  <= last_grant_r;
`endif
          end
        end
        ISSUE: begin
          hr_wr_req <= we_r;
          hr_rd_req <= ~we_r;
          state_r   <= WAIT_BUSY;
`ifdef HRAM_ARB_TIMEOUT_EN
          cnt_r     <= '0;
`endif
        end
        WAIT_BUSY, WAIT_IDLE: begin
          if ((state_r == WAIT_BUSY) && hr_busy) begin
            state_r <= WAIT_IDLE;
`ifdef HRAM_ARB_TIMEOUT_EN
            cnt_r   <= '0;
`endif
          end else if ((state_r == WAIT_IDLE) && !hr_busy) begin
            state_r <= IDLE;
          end else if (timeout_hit_s) begin
            state_r <= IDLE;
`ifdef HRAM_ARB_TIMEOUT_EN
            // An aborted transaction must not count as this port's turn.
            timeout_err_r <= 1'b1;
            last_grant_r  <= prev_grant_r;
`endif
          end else begin
`ifdef HRAM_ARB_TIMEOUT_EN
            cnt_r <= cnt_r + CNT_W'(1);
`endif
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hyperram_arbiter.sv
// Directed self-checking bench for hyperram_arbiter; the bench plays hyper_xface by hand.
module tb_hyperram_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        p0_req = 1'b0, p0_we = 1'b0, p1_req = 1'b0, p1_we = 1'b0;
  logic [31:0] p0_addr = 32'h0, p0_wdata = 32'h0, p1_addr = 32'h0, p1_wdata = 32'h0;
  logic [3:0]  p0_be = 4'h0, p1_be = 4'h0;
  logic        p0_ack, p0_rvalid, p1_ack, p1_rvalid;
  logic [31:0] p0_rdata, p1_rdata;
  logic        hr_rd_req, hr_wr_req;
  logic [31:0] hr_addr, hr_wr_d;
  logic [3:0]  hr_wr_byte_en;
  logic [5:0]  hr_rd_num_dwords;
  logic        hr_busy = 1'b0, hr_rd_rdy = 1'b0;
  logic [31:0] hr_rd_d = 32'h0;
  logic        timeout_err;
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  hyperram_arbiter #(.TIMEOUT_CYCLES(16), .CNT_W(5)) dut (
    .clk(clk), .reset(reset),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_be(p0_be),
    .p0_ack(p0_ack), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_be(p1_be),
    .p1_ack(p1_ack), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
    .hr_rd_req(hr_rd_req), .hr_wr_req(hr_wr_req), .hr_addr(hr_addr), .hr_wr_d(hr_wr_d),
    .hr_wr_byte_en(hr_wr_byte_en), .hr_rd_num_dwords(hr_rd_num_dwords),
    .hr_busy(hr_busy), .hr_rd_rdy(hr_rd_rdy), .hr_rd_d(hr_rd_d), .timeout_err(timeout_err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives ISSUE, a short busy window and the return to IDLE.
  task automatic finish_xact();
    step();
    hr_busy = 1'b1;
    step();
    hr_busy = 1'b0;
    step();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    total++; if ({p0_ack, p1_ack, p0_rvalid, p1_rvalid} !== 4'b0000) begin bad++; $display("FAIL reset_pulses got=%b exp=0000", {p0_ack, p1_ack, p0_rvalid, p1_rvalid}); end
    total++; if ({hr_rd_req, hr_wr_req, timeout_err} !== 3'b000) begin bad++; $display("FAIL reset_hr_req got=%b exp=000", {hr_rd_req, hr_wr_req, timeout_err}); end
    total++; if ({p0_rdata, p1_rdata, hr_addr, hr_wr_d} !== 128'h0) begin bad++; $display("FAIL reset_data got=%h exp=0", {p0_rdata, p1_rdata, hr_addr, hr_wr_d}); end
    total++; if (hr_wr_byte_en !== 4'h0) begin bad++; $display("FAIL reset_be got=%h exp=0", hr_wr_byte_en); end
    total++; if (hr_rd_num_dwords !== 6'h01) begin bad++; $display("FAIL num_dwords got=%h exp=01", hr_rd_num_dwords); end
  endtask

  task automatic test_write();
    p0_req = 1'b1; p0_we = 1'b1; p0_addr = 32'h10; p0_wdata = 32'hDEADBEEF; p0_be = 4'hF;
    step();
    total++; if ({p0_ack, p1_ack, hr_wr_req} !== 3'b100) begin bad++; $display("FAIL wr_ack got=%b exp=100", {p0_ack, p1_ack, hr_wr_req}); end
    p0_req = 1'b0;
    step();
    total++; if ({hr_wr_req, hr_rd_req, p0_ack} !== 3'b100) begin bad++; $display("FAIL wr_issue got=%b exp=100", {hr_wr_req, hr_rd_req, p0_ack}); end
    total++; if ({hr_addr, hr_wr_d, hr_wr_byte_en} !== {32'h10, 32'hDEADBEEF, 4'hF}) begin bad++; $display("FAIL wr_fields got=%h exp=%h", {hr_addr, hr_wr_d, hr_wr_byte_en}, {32'h10, 32'hDEADBEEF, 4'hF}); end
    p1_req = 1'b1; p1_we = 1'b0; p1_addr = 32'h10; p1_wdata = 32'h0; p1_be = 4'h0;
    step();
    total++; if ({hr_wr_req, p1_ack} !== 2'b00) begin bad++; $display("FAIL wr_pulse_len got=%b exp=00", {hr_wr_req, p1_ack}); end
    hr_busy = 1'b1;
    step();
    hr_rd_rdy = 1'b1; hr_rd_d = 32'h11111111;
    step();
    hr_rd_rdy = 1'b0;
    total++; if ({p0_rvalid, p1_rvalid} !== 2'b00) begin bad++; $display("FAIL wr_rdrdy_ignored got=%b exp=00", {p0_rvalid, p1_rvalid}); end
    for (int i = 0; i < 3; i++) begin
      step();
      total++; if (p1_ack !== 1'b0) begin bad++; $display("FAIL wr_hold_grant got=%b exp=0", p1_ack); end
    end
    hr_busy = 1'b0;
    step();
    total++; if (p1_ack !== 1'b0) begin bad++; $display("FAIL wr_idle_no_ack got=%b exp=0", p1_ack); end
    step();
    total++; if (p1_ack !== 1'b1) begin bad++; $display("FAIL wr_next_grant got=%b exp=1", p1_ack); end
    p1_req = 1'b0;
  endtask

  // Continues the p1 read granted at the end of test_write.
  task automatic test_read();
    step();
    total++; if ({hr_rd_req, hr_wr_req, hr_addr} !== {2'b10, 32'h10}) begin bad++; $display("FAIL rd_issue got=%h exp=%h", {hr_rd_req, hr_wr_req, hr_addr}, {2'b10, 32'h10}); end
    step();
    total++; if (hr_rd_req !== 1'b0) begin bad++; $display("FAIL rd_pulse_len got=%b exp=0", hr_rd_req); end
    hr_busy = 1'b1;
    step();
    hr_rd_rdy = 1'b1; hr_rd_d = 32'hDEADBEEF;
    step();
    hr_rd_rdy = 1'b0; hr_rd_d = 32'h0;
    total++; if ({p1_rvalid, p0_rvalid, p1_rdata} !== {2'b10, 32'hDEADBEEF}) begin bad++; $display("FAIL rd_return got=%h exp=%h", {p1_rvalid, p0_rvalid, p1_rdata}, {2'b10, 32'hDEADBEEF}); end
    step();
    total++; if ({p1_rvalid, p1_rdata} !== {1'b0, 32'hDEADBEEF}) begin bad++; $display("FAIL rd_hold got=%h exp=%h", {p1_rvalid, p1_rdata}, {1'b0, 32'hDEADBEEF}); end
    hr_busy = 1'b0;
    step();
  endtask

  task automatic test_busy_stall();
    hr_busy = 1'b1;
    p0_req = 1'b1; p0_we = 1'b1; p0_addr = 32'h20; p0_wdata = 32'h12345678; p0_be = 4'h3;
    for (int i = 0; i < 4; i++) begin
      step();
      total++; if (p0_ack !== 1'b0) begin bad++; $display("FAIL stall_no_ack got=%b exp=0", p0_ack); end
    end
    hr_busy = 1'b0;
    step();
    total++; if ({p0_ack, hr_addr, hr_wr_byte_en} !== {1'b1, 32'h20, 4'h3}) begin bad++; $display("FAIL stall_release got=%h exp=%h", {p0_ack, hr_addr, hr_wr_byte_en}, {1'b1, 32'h20, 4'h3}); end
    p0_req = 1'b0;
    finish_xact();
  endtask

  task automatic test_reset_mid();
    p1_req = 1'b1; p1_we = 1'b0; p1_addr = 32'h80;
    step();
    p1_req = 1'b0;
    step();
    hr_busy = 1'b1;
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    hr_busy = 1'b0; hr_rd_rdy = 1'b1; hr_rd_d = 32'hCAFEF00D;
    step();
    hr_rd_rdy = 1'b0;
    total++; if ({p0_rvalid, p1_rvalid, p0_ack, p1_ack, hr_rd_req, hr_wr_req} !== 6'b0) begin bad++; $display("FAIL rst_mid_pulses got=%b exp=000000", {p0_rvalid, p1_rvalid, p0_ack, p1_ack, hr_rd_req, hr_wr_req}); end
    total++; if ({p1_rdata, hr_addr, hr_wr_d, hr_wr_byte_en} !== 100'h0) begin bad++; $display("FAIL rst_mid_regs got=%h exp=0", {p1_rdata, hr_addr, hr_wr_d, hr_wr_byte_en}); end
    p0_req = 1'b1; p0_we = 1'b1; p1_req = 1'b1; p1_we = 1'b1;
    step();
    total++; if ({p0_ack, p1_ack} !== 2'b10) begin bad++; $display("FAIL rst_mid_idle got=%b exp=10", {p0_ack, p1_ack}); end
    p0_req = 1'b0; p1_req = 1'b0;
    finish_xact();
  endtask

  task automatic test_back_to_back();
    logic [5:0] exp_order = 6'b101010;
    int n0 = 3, n1 = 3, got = 0, busy_cnt = 0, since = 0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    p0_we = 1'b1; p1_we = 1'b1; p0_addr = 32'h100; p1_addr = 32'h200;
    p0_req = 1'b1; p1_req = 1'b1;
    for (int cyc = 0; cyc < 80; cyc++) begin
      step();
      if (p0_ack || p1_ack) begin
        total++; if ({p0_ack, p1_ack} === 2'b11 || since != 0) begin bad++; $display("FAIL rr_single_ack got=%b since=%0d exp=one ack per xact", {p0_ack, p1_ack}, since); end
        since = 1;
        if (got < 6) begin
          total++; if (p1_ack !== exp_order[got]) begin bad++; $display("FAIL rr_order grant%0d got=p%0d exp=p%0d", got, p1_ack, exp_order[got]); end
        end
        got++;
        if (p0_ack) begin n0--; if (n0 == 0) p0_req = 1'b0; end
        if (p1_ack) begin n1--; if (n1 == 0) p1_req = 1'b0; end
      end
      if (hr_wr_req || hr_rd_req) begin since = 0; busy_cnt = 3; end
      hr_busy = (busy_cnt > 0);
      if (busy_cnt > 0) busy_cnt--;
    end
    hr_busy = 1'b0;
    total++; if (got != 6) begin bad++; $display("FAIL rr_count got=%0d exp=6", got); end
  endtask

`ifdef HRAM_ARB_TIMEOUT_EN
  task automatic test_timeout();
    p0_req = 1'b1; p0_we = 1'b0; p0_addr = 32'h40;
    step();
    total++; if (p0_ack !== 1'b1) begin bad++; $display("FAIL to_ack got=%b exp=1", p0_ack); end
    p0_req = 1'b0; p1_req = 1'b1; p1_we = 1'b1; p1_addr = 32'h44;
    step();
    for (int i = 1; i < 16; i++) begin
      step();
      total++; if ({timeout_err, p1_ack} !== 2'b00) begin bad++; $display("FAIL to_early cyc%0d got=%b exp=00", i, {timeout_err, p1_ack}); end
    end
    step();
    total++; if ({timeout_err, p0_rvalid} !== 2'b10) begin bad++; $display("FAIL to_pulse got=%b exp=10", {timeout_err, p0_rvalid}); end
    step();
    total++; if ({timeout_err, p1_ack} !== 2'b01) begin bad++; $display("FAIL to_next_grant got=%b exp=01", {timeout_err, p1_ack}); end
    p1_req = 1'b0;
    finish_xact();
  endtask
`endif

  initial begin
    test_reset();
    test_write();
    test_read();
    test_busy_stall();
    test_reset_mid();
    test_back_to_back();
`ifdef HRAM_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hyperram_arbiter.md
Name: hyperram_arbiter

Overview:
Two-port arbiter and sequencer in front of hyper_xface. It shares one HyperRAM controller between two requesters, for example the UART command engine and a future DMA/video master. It handles single-dword reads and writes and pulses hyper_xface rd_req/wr_req. It tracks hyper_xface busy to find the end of each transaction and routes read data back to the owning port.

Parameters:
TIMEOUT_CYCLES, 1024, watchdog limit in clk cycles per transaction phase; used only with HRAM_ARB_TIMEOUT_EN.
CNT_W, 11, timeout counter width; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
clk  in  1  system clock (same clock as hyper_xface)
reset  in  1  synchronous, active-high reset
p0_req  in  1  port 0 request; held high until p0_ack
p0_we  in  1  port 0: 1 = write, 0 = read
p0_addr  in  32  port 0 address
p0_wdata  in  32  port 0 write data
p0_be  in  4  port 0 write byte enables
p0_ack  out  1  one-cycle grant pulse; request fields are sampled on this cycle
p0_rvalid  out  1  one-cycle read-data-valid pulse
p0_rdata  out  32  read data; held until the next p0_rvalid
p1_req, p1_we, p1_addr, p1_wdata, p1_be, p1_ack, p1_rvalid, p1_rdata: same as the port 0 signals, for port 1
hr_rd_req  out  1  to hyper_xface rd_req
hr_wr_req  out  1  to hyper_xface wr_req
hr_addr  out  32  to hyper_xface addr
hr_wr_d  out  32  to hyper_xface wr_d
hr_wr_byte_en  out  4  to hyper_xface wr_byte_en
hr_rd_num_dwords  out  6  constant 6'h1
hr_busy  in  1  from hyper_xface busy
hr_rd_rdy  in  1  from hyper_xface rd_rdy
hr_rd_d  in  32  from hyper_xface rd_d
timeout_err  out  1  one-cycle pulse on watchdog abort

Behaviour:
- All outputs are registered. Reset values: acks, rvalids, hr_rd_req, hr_wr_req and timeout_err = 0; rdata, hr_addr and hr_wr_d = 0; hr_wr_byte_en = 4'h0; state = IDLE; owner = 0; last_grant = 1, so port 0 wins the first tie.
- Reset asserted mid-transaction forces IDLE within 1 cycle and drops any pending request pulse. Any rd_rdy from the dropped transaction is ignored.
- States: IDLE -> ISSUE -> WAIT_BUSY -> WAIT_IDLE -> IDLE.
- IDLE, no requests: remain in IDLE.
- IDLE, one or more requests with hr_busy = 0:
  - Choose the winner. If only one port requests, it wins. If both request, the port != last_grant wins (round robin).
  - Latch the winner's addr/wdata/be/we into the hr_* registers.
  - Set owner and last_grant to the winner.
  - Pulse px_ack for 1 cycle, then go to ISSUE.
- IDLE, any request with hr_busy = 1: stall in IDLE, no ack.
- ISSUE: assert hr_wr_req (we = 1) or hr_rd_req (we = 0) for exactly 1 cycle, then go to WAIT_BUSY. Latency: request asserted -> hr_*_req high on the 2nd clk edge.
- WAIT_BUSY: wait for hr_busy = 1, then go to WAIT_IDLE. This covers hyper_xface's start delay.
- WAIT_IDLE: wait for hr_busy = 0, then go to IDLE. The next grant may occur on the following cycle.
- Read return: on hr_rd_rdy = 1 while owner's transaction is a read (WAIT_BUSY or WAIT_IDLE):
  - latch hr_rd_d into p<owner>_rdata;
  - pulse p<owner>_rvalid on the next cycle.
- hr_rd_rdy in IDLE/ISSUE, or during a write, is ignored.
- A requester dropping req before ack: no grant is issued. This is legal but discouraged.
- A port may re-request on the cycle after its ack; it waits for the current transaction to finish.
- Without the timeout feature there is no watchdog; a stuck busy hangs the arbiter.

Optional Feature:
HRAM_ARB_TIMEOUT_EN.
- Defined:
  - A phase counter clears on entry to WAIT_BUSY and again on entry to WAIT_IDLE.
  - When the counter reaches TIMEOUT_CYCLES in either state, go to IDLE and pulse timeout_err for 1 cycle.
  - A timed-out read issues no rvalid.
  - An aborted transaction does not update last_grant.
- Undefined: the counter is not built; timeout_err is tied to 0.

Test Plan:
- p0 write: addr 0x10, wdata 0xDEADBEEF, be 0xF -> p0_ack 1 cycle; hr_wr_req 1-cycle pulse with hr_addr 0x10, hr_wr_d 0xDEADBEEF; next grant only after hr_busy falls.
- p1 read: addr 0x10, model returns 0xDEADBEEF -> hr_rd_req pulse; p1_rvalid 1 cycle with p1_rdata 0xDEADBEEF; p0_rvalid stays 0.
- p0 and p1 request on the same cycle from reset, three times back-to-back -> grant order p0, p1, p0, p1, p0, p1; never two acks in one transaction.
- Request while hr_busy is held 1 by the model -> no ack until busy = 0.
- Reset pulsed in WAIT_IDLE during a p1 read, then model asserts rd_rdy -> no p1_rvalid; state IDLE; all outputs at reset values.
- With HRAM_ARB_TIMEOUT_EN, TIMEOUT_CYCLES = 16, model never raises busy -> timeout_err pulse 16 cycles after WAIT_BUSY entry; next pending request is granted.
